// File: rtl/friscv_run_monitor.sv
// Run monitor for RISC-V test harts: holds core reset, counts RUN cycles, latches
// halts and their cause, and reports done/pass/timeout until the next srst.
module friscv_run_monitor #(
  parameter int unsigned NB_HART    = 1,
  parameter int unsigned TIMEOUT    = 10000,
  parameter int unsigned CNT_W      = 32,
  parameter logic [7:0]  STOP_MASK  = 8'h12,
  parameter bit          ALL_HARTS  = 1'b0,
  parameter int unsigned RESET_HOLD = 5
) (
  input  logic                 aclk,
  input  logic                 srst,
  input  logic [NB_HART*8-1:0] status,
  input  logic [NB_HART-1:0]   x31_zero,
  output logic                 core_rstn,
  output logic [NB_HART-1:0]   halted,
  output logic [7:0]           halt_cause,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycles
);

  localparam int unsigned HOLD_MAX = (RESET_HOLD > 0) ? RESET_HOLD - 1 : 0;
  localparam int unsigned HOLD_W   = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

  typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;

  state_t              state_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [NB_HART-1:0]  hit_c;
  logic [NB_HART-1:0]  halted_d;
  logic [7:0]          cause_d;
  logic                stop_c;
  logic                last_c;

  // New halts this cycle, accumulated cause and the stop/timeout conditions
  always_comb begin
    hit_c   = '0;
    cause_d = halt_cause;
    for (int unsigned h = 0; h < NB_HART; h++) begin
      hit_c[h] = (|(status[8*h +: 8] & STOP_MASK)) && !halted[h];
      if (hit_c[h]) begin
        cause_d = cause_d | status[8*h +: 8];
      end
    end
    halted_d = halted | hit_c;
    stop_c   = ALL_HARTS ? (&halted_d) : (|halted_d);
    last_c   = (cycles == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q    <= HOLD;
      hold_q     <= '0;
      core_rstn  <= 1'b0;
      halted     <= '0;
      halt_cause <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      cycles     <= '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_q == HOLD_W'(HOLD_MAX)) begin
            state_q   <= RUN;
            core_rstn <= 1'b1;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        RUN: begin
          halted     <= halted_d;
          halt_cause <= cause_d;
          // Saturate at TIMEOUT-1 so the counter can never wrap
          if (!last_c) begin
            cycles <= cycles + CNT_W'(1);
          end
          if (stop_c) begin
            state_q <= DONE;
            done    <= 1'b1;
            pass    <= &x31_zero;
          end else if (last_c) begin
            state_q <= DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_friscv_run_monitor.sv
// Bench for friscv_run_monitor: four parameterisations share clock and srst; a
// scoreboard queue holds the expected completion of each instance.
module tb_friscv_run_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst;
  logic [7:0]  status_a, status_b;
  logic [15:0] status_c, status_d;
  logic        x31_a, x31_b;
  logic [1:0]  x31_c, x31_d;

  logic        core_rstn_a, core_rstn_b, core_rstn_c, core_rstn_d;
  logic        halted_a, halted_b;
  logic [1:0]  halted_c, halted_d;
  logic [7:0]  halt_cause_a, halt_cause_b, halt_cause_c, halt_cause_d;
  logic        done_a, done_b, done_c, done_d;
  logic        pass_a, pass_b, pass_c, pass_d;
  logic        timeout_a, timeout_b, timeout_c, timeout_d;
  logic [31:0] cycles_a, cycles_b, cycles_c, cycles_d;

  friscv_run_monitor u_a (
    .aclk(clk), .srst(srst), .status(status_a), .x31_zero(x31_a),
    .core_rstn(core_rstn_a), .halted(halted_a), .halt_cause(halt_cause_a),
    .done(done_a), .pass(pass_a), .timeout(timeout_a), .cycles(cycles_a)
  );

  friscv_run_monitor #(.TIMEOUT(50)) u_b (
    .aclk(clk), .srst(srst), .status(status_b), .x31_zero(x31_b),
    .core_rstn(core_rstn_b), .halted(halted_b), .halt_cause(halt_cause_b),
    .done(done_b), .pass(pass_b), .timeout(timeout_b), .cycles(cycles_b)
  );

  friscv_run_monitor #(.NB_HART(2), .ALL_HARTS(1'b1)) u_c (
    .aclk(clk), .srst(srst), .status(status_c), .x31_zero(x31_c),
    .core_rstn(core_rstn_c), .halted(halted_c), .halt_cause(halt_cause_c),
    .done(done_c), .pass(pass_c), .timeout(timeout_c), .cycles(cycles_c)
  );

  friscv_run_monitor #(.NB_HART(2), .ALL_HARTS(1'b0)) u_d (
    .aclk(clk), .srst(srst), .status(status_d), .x31_zero(x31_d),
    .core_rstn(core_rstn_d), .halted(halted_d), .halt_cause(halt_cause_d),
    .done(done_d), .pass(pass_d), .timeout(timeout_d), .cycles(cycles_d)
  );

  typedef struct packed {
    logic [31:0] k;
    logic        pass;
    logic        tmo;
    logic [7:0]  cause;
    logic [1:0]  halted;
    logic [31:0] cyc;
  } res_t;

  typedef struct packed {
    logic [1:0] inst;
    res_t       r;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input int inst, input int k, input logic p, input logic t,
                      input logic [7:0] cause, input logic [1:0] h, input int cyc);
    exp_t e;
    e.inst     = 2'(inst);
    e.r.k      = 32'(k);
    e.r.pass   = p;
    e.r.tmo    = t;
    e.r.cause  = cause;
    e.r.halted = h;
    e.r.cyc    = 32'(cyc);
    sb.push_back(e);
  endtask

  function automatic res_t observe(input int inst, input int k);
    res_t r;
    r   = '0;
    r.k = 32'(k);
    case (inst)
      0: begin r.pass = pass_a; r.tmo = timeout_a; r.cause = halt_cause_a;
               r.halted = {1'b0, halted_a}; r.cyc = cycles_a; end
      1: begin r.pass = pass_b; r.tmo = timeout_b; r.cause = halt_cause_b;
               r.halted = {1'b0, halted_b}; r.cyc = cycles_b; end
      2: begin r.pass = pass_c; r.tmo = timeout_c; r.cause = halt_cause_c;
               r.halted = halted_c; r.cyc = cycles_c; end
      default: begin r.pass = pass_d; r.tmo = timeout_d; r.cause = halt_cause_d;
               r.halted = halted_d; r.cyc = cycles_d; end
    endcase
    return r;
  endfunction

  // One run from srst: reset/hold checks, then RUN cycles k=0..k_end with stimulus
  task automatic run(input bit b_stop, input int k_end);
    logic [3:0] prev;
    logic [3:0] now;
    bit         found;
    srst     = 1'b1;
    status_a = '0; status_b = '0; status_c = '0; status_d = '0;
    step();
    srst     = 1'b0;
    status_a = 8'h02;  // must be ignored while in HOLD
    chk("rst_a", 128'({core_rstn_a, done_a, pass_a, timeout_a, halted_a, halt_cause_a, cycles_a}), 128'(0));
    chk("rst_b", 128'({core_rstn_b, done_b, pass_b, timeout_b, halted_b, halt_cause_b, cycles_b}), 128'(0));
    chk("rst_c", 128'({core_rstn_c, done_c, pass_c, timeout_c, halted_c, halt_cause_c, cycles_c}), 128'(0));
    chk("rst_d", 128'({core_rstn_d, done_d, pass_d, timeout_d, halted_d, halt_cause_d, cycles_d}), 128'(0));
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("core_rstn_hold%0d", i), 128'(core_rstn_a), 128'(i == 5));
    end
    chk("cycles_start", 128'(cycles_a), 128'(0));
    prev = '0;
    if (!b_stop) push(1, 50, 1'b0, 1'b1, 8'h00, 2'b00, 49);
    for (int k = 0; k <= k_end; k++) begin
      now = {done_d, done_c, done_b, done_a};
      for (int i = 0; i < 4; i++) begin
        if (now[i] && !prev[i]) begin
          found = 1'b0;
          for (int j = 0; j < sb.size(); j++) begin
            if (!found && sb[j].inst == 2'(i)) begin
              chk($sformatf("done_inst%0d", i), 128'(observe(i, k)), 128'(sb[j].r));
              sb.delete(j);
              found = 1'b1;
            end
          end
          chk($sformatf("expected_done_inst%0d", i), 128'(found), 128'(1));
        end
      end
      prev = now;
      if (k == 11) chk("c_halted_k11", 128'({done_c, halted_c}), 128'(3'b001));
      if (k == 26) chk("d_nohalt_k26", 128'({done_d, halted_d}), 128'(0));
      if (k == 37) chk("a_cycles_k37", 128'(cycles_a), 128'(37));
      if (k == k_end) break;
      status_a = (k == 100) ? 8'h02 : 8'h00;
      if (k == 100) push(0, 101, 1'b1, 1'b0, 8'h02, 2'b01, 101);
      status_b = (b_stop && k == 49) ? 8'h10 : 8'h00;
      if (b_stop && k == 49) push(1, 50, 1'b1, 1'b0, 8'h10, 2'b01, 49);
      case (k)
        10:      status_c = 16'h0002;
        20:      status_c = 16'h1000;
        25:      status_c = 16'hffff;  // arrives after DONE, must be ignored
        default: status_c = 16'h0000;
      endcase
      if (k == 20) push(2, 21, 1'b0, 1'b0, 8'h12, 2'b11, 21);
      case (k)
        25:      status_d = 16'h0100;
        30:      status_d = 16'h0200;
        default: status_d = 16'h0000;
      endcase
      if (k == 30) push(3, 31, 1'b1, 1'b0, 8'h02, 2'b10, 31);
      step();
    end
    if (k_end >= 110) begin
      chk("pending_done", 128'(sb.size()), 128'(0));
      chk("c_frozen", 128'({halted_c, halt_cause_c, cycles_c}), 128'({2'b11, 8'h12, 32'd21}));
      chk("a_frozen", 128'({done_a, cycles_a}), 128'({1'b1, 32'd101}));
    end
    sb.delete();
  endtask

  initial begin
    srst  = 1'b1;
    x31_a = 1'b1;
    x31_b = 1'b1;
    x31_c = 2'b01;
    x31_d = 2'b11;
    status_a = '0; status_b = '0; status_c = '0; status_d = '0;
    run(1'b0, 110);  // full run, B times out
    run(1'b0, 40);   // starts from DONE, aborted mid-RUN by the next srst
    run(1'b1, 110);  // repeat run, B stops on its last cycle
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
